// File: rtl/regfile_write_queue.sv
// Writeback request queue in front of the register file write port.
// Buffers requests in order, drains one per cycle, and answers read-port bypass lookups.
module regfile_write_queue #(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              Reset,
  input  logic              In_Valid,
  output logic              In_Ready,
  input  logic [ADDR_W-1:0] In_Addr,
  input  logic [DATA_W-1:0] In_Data,
  input  logic              Drain_En,
  output logic [ADDR_W-1:0] W_Addr,
  output logic [DATA_W-1:0] W_Data,
  output logic              Write_Reg,
  input  logic [ADDR_W-1:0] R_Addr_A,
  input  logic [ADDR_W-1:0] R_Addr_B,
  output logic              Byp_Hit_A,
  output logic [DATA_W-1:0] Byp_Data_A,
  output logic              Byp_Hit_B,
  output logic [DATA_W-1:0] Byp_Data_B
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [ADDR_W-1:0] r_addr [DEPTH];
  logic [DATA_W-1:0] r_data [DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [CNT_W-1:0]  r_count;

  logic              w_empty;
  logic              w_push;
  logic              w_pop;
  logic [PTR_W-1:0]  w_slot_idx [DEPTH];
  logic [DEPTH-1:0]  w_slot_vld;

  // Handshake and drain qualifiers; writes to register 0 are accepted but dropped
  assign w_empty   = (r_count == '0);
  assign In_Ready  = (r_count < CNT_W'(DEPTH));
  assign w_push    = In_Valid && In_Ready && (In_Addr != '0);
  assign Write_Reg = !w_empty && Drain_En;
  assign w_pop     = Write_Reg;

  // Head entry is presented whenever the queue is non-empty, zero otherwise
  assign W_Addr = w_empty ? '0 : r_addr[r_rd_ptr];
  assign W_Data = w_empty ? '0 : r_data[r_rd_ptr];

  // Queue storage, pointers and occupancy
  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_addr[i] <= '0;
        r_data[i] <= '0;
      end
    end else begin
      if (w_push) begin
        r_addr[r_wr_ptr] <= In_Addr;
        r_data[r_wr_ptr] <= In_Data;
        r_wr_ptr         <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage slots listed oldest-first with their occupancy flag
  always_comb begin
    for (int k = 0; k < DEPTH; k++) begin
      w_slot_idx[k] = r_rd_ptr + PTR_W'(k);
      w_slot_vld[k] = (CNT_W'(k) < r_count);
    end
  end

  // Bypass search; later (younger) matches override earlier ones, head included
  always_comb begin
    Byp_Hit_A  = 1'b0;
    Byp_Data_A = '0;
    Byp_Hit_B  = 1'b0;
    Byp_Data_B = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if (w_slot_vld[k] && (R_Addr_A != '0) && (r_addr[w_slot_idx[k]] == R_Addr_A)) begin
        Byp_Hit_A  = 1'b1;
        Byp_Data_A = r_data[w_slot_idx[k]];
      end
      if (w_slot_vld[k] && (R_Addr_B != '0) && (r_addr[w_slot_idx[k]] == R_Addr_B)) begin
        Byp_Hit_B  = 1'b1;
        Byp_Data_B = r_data[w_slot_idx[k]];
      end
    end
  end

endmodule

// File: tb/tb_regfile_write_queue.sv
// Bench for regfile_write_queue: directed vector table, hand-written corner
// sequences (push+pop at steady occupancy, async reset) and random traffic
// against a queue-based reference model.
module tb_regfile_write_queue;

  localparam int unsigned DEPTH  = 4;
  localparam int unsigned ADDR_W = 5;
  localparam int unsigned DATA_W = 32;

  logic              clk = 1'b0;
  logic              Reset;
  logic              In_Valid;
  logic              In_Ready;
  logic [ADDR_W-1:0] In_Addr;
  logic [DATA_W-1:0] In_Data;
  logic              Drain_En;
  logic [ADDR_W-1:0] W_Addr;
  logic [DATA_W-1:0] W_Data;
  logic              Write_Reg;
  logic [ADDR_W-1:0] R_Addr_A;
  logic [ADDR_W-1:0] R_Addr_B;
  logic              Byp_Hit_A;
  logic [DATA_W-1:0] Byp_Data_A;
  logic              Byp_Hit_B;
  logic [DATA_W-1:0] Byp_Data_B;

  regfile_write_queue #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .Reset(Reset),
    .In_Valid(In_Valid), .In_Ready(In_Ready), .In_Addr(In_Addr), .In_Data(In_Data),
    .Drain_En(Drain_En), .W_Addr(W_Addr), .W_Data(W_Data), .Write_Reg(Write_Reg),
    .R_Addr_A(R_Addr_A), .R_Addr_B(R_Addr_B),
    .Byp_Hit_A(Byp_Hit_A), .Byp_Data_A(Byp_Data_A),
    .Byp_Hit_B(Byp_Hit_B), .Byp_Data_B(Byp_Data_B)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic              v;
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] d;
    logic              dr;
    logic [ADDR_W-1:0] ra;
    logic [ADDR_W-1:0] rb;
    logic              e_rdy;
    logic              e_wr;
    logic [ADDR_W-1:0] e_wa;
    logic [DATA_W-1:0] e_wd;
    logic              e_ha;
    logic [DATA_W-1:0] e_da;
    logic              e_hb;
    logic [DATA_W-1:0] e_db;
  } vec_t;

  typedef struct {
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] d;
  } ent_t;

  int   n_vec = 0;
  int   n_err = 0;
  ent_t mq[$];
  vec_t tbl[21];

  function automatic vec_t mk(logic v, logic [ADDR_W-1:0] a, logic [DATA_W-1:0] d, logic dr,
                              logic [ADDR_W-1:0] ra, logic [ADDR_W-1:0] rb,
                              logic e_rdy, logic e_wr, logic [ADDR_W-1:0] e_wa,
                              logic [DATA_W-1:0] e_wd, logic e_ha, logic [DATA_W-1:0] e_da,
                              logic e_hb, logic [DATA_W-1:0] e_db);
    vec_t r;
    r.v = v; r.a = a; r.d = d; r.dr = dr; r.ra = ra; r.rb = rb;
    r.e_rdy = e_rdy; r.e_wr = e_wr; r.e_wa = e_wa; r.e_wd = e_wd;
    r.e_ha = e_ha; r.e_da = e_da; r.e_hb = e_hb; r.e_db = e_db;
    return r;
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic chk_all(string tag, logic rdy, logic wr, logic [ADDR_W-1:0] wa,
                         logic [DATA_W-1:0] wd, logic ha, logic [DATA_W-1:0] da,
                         logic hb, logic [DATA_W-1:0] db);
    chk({tag, ".In_Ready"},   32'(In_Ready),   32'(rdy));
    chk({tag, ".Write_Reg"},  32'(Write_Reg),  32'(wr));
    chk({tag, ".W_Addr"},     32'(W_Addr),     32'(wa));
    chk({tag, ".W_Data"},     W_Data,          wd);
    chk({tag, ".Byp_Hit_A"},  32'(Byp_Hit_A),  32'(ha));
    chk({tag, ".Byp_Data_A"}, Byp_Data_A,      da);
    chk({tag, ".Byp_Hit_B"},  32'(Byp_Hit_B),  32'(hb));
    chk({tag, ".Byp_Data_B"}, Byp_Data_B,      db);
  endtask

  // Reference: queue contents give every output directly
  task automatic model_check(string tag);
    logic              ha = 1'b0, hb = 1'b0;
    logic [DATA_W-1:0] da = '0, db = '0;
    logic [ADDR_W-1:0] wa = '0;
    logic [DATA_W-1:0] wd = '0;
    foreach (mq[i]) begin
      if (R_Addr_A != 0 && mq[i].a == R_Addr_A) begin ha = 1'b1; da = mq[i].d; end
      if (R_Addr_B != 0 && mq[i].a == R_Addr_B) begin hb = 1'b1; db = mq[i].d; end
    end
    if (mq.size() != 0) begin wa = mq[0].a; wd = mq[0].d; end
    chk_all(tag, logic'(mq.size() < DEPTH), logic'(mq.size() != 0 && Drain_En), wa, wd, ha, da, hb, db);
  endtask

  task automatic model_edge();
    logic pop = (mq.size() != 0) && Drain_En;
    logic acc = In_Valid && (mq.size() < DEPTH);
    ent_t e;
    if (pop) void'(mq.pop_front());
    if (acc && In_Addr != 0) begin
      e.a = In_Addr; e.d = In_Data;
      mq.push_back(e);
    end
  endtask

  task automatic drive(logic v, logic [ADDR_W-1:0] a, logic [DATA_W-1:0] d, logic dr,
                       logic [ADDR_W-1:0] ra, logic [ADDR_W-1:0] rb);
    In_Valid = v; In_Addr = a; In_Data = d; Drain_En = dr; R_Addr_A = ra; R_Addr_B = rb;
  endtask

  // One clock cycle: drive, check against model at negedge, advance model at posedge
  task automatic cyc(string tag, logic v, logic [ADDR_W-1:0] a, logic [DATA_W-1:0] d, logic dr,
                     logic [ADDR_W-1:0] ra, logic [ADDR_W-1:0] rb);
    drive(v, a, d, dr, ra, rb);
    @(negedge clk);
    model_check(tag);
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    drive(1'b0, '0, '0, 1'b0, '0, '0);
    mq.delete();
    repeat (2) @(posedge clk);
    #2 Reset = 1'b0;
    #1;
  endtask

  initial begin
    //          v  a   d        dr ra rb  rdy wr wa wd       ha da       hb db
    tbl[0]  = mk(1, 3, 32'h11,  1, 0, 0,  1,  0, 0, 32'h0,   0, 32'h0,   0, 32'h0);
    tbl[1]  = mk(0, 0, 32'h0,   1, 3, 0,  1,  1, 3, 32'h11,  1, 32'h11,  0, 32'h0);
    tbl[2]  = mk(0, 0, 32'h0,   1, 3, 0,  1,  0, 0, 32'h0,   0, 32'h0,   0, 32'h0);
    tbl[3]  = mk(1, 1, 32'hA1,  0, 0, 0,  1,  0, 0, 32'h0,   0, 32'h0,   0, 32'h0);
    tbl[4]  = mk(1, 2, 32'hA2,  0, 0, 0,  1,  0, 1, 32'hA1,  0, 32'h0,   0, 32'h0);
    tbl[5]  = mk(1, 4, 32'hA4,  0, 0, 0,  1,  0, 1, 32'hA1,  0, 32'h0,   0, 32'h0);
    tbl[6]  = mk(1, 5, 32'hA5,  0, 0, 0,  1,  0, 1, 32'hA1,  0, 32'h0,   0, 32'h0);
    tbl[7]  = mk(1, 6, 32'hA6,  0, 0, 0,  0,  0, 1, 32'hA1,  0, 32'h0,   0, 32'h0);
    tbl[8]  = mk(0, 0, 32'h0,   1, 6, 5,  0,  1, 1, 32'hA1,  0, 32'h0,   1, 32'hA5);
    tbl[9]  = mk(0, 0, 32'h0,   1, 0, 0,  1,  1, 2, 32'hA2,  0, 32'h0,   0, 32'h0);
    tbl[10] = mk(0, 0, 32'h0,   1, 0, 0,  1,  1, 4, 32'hA4,  0, 32'h0,   0, 32'h0);
    tbl[11] = mk(0, 0, 32'h0,   1, 0, 0,  1,  1, 5, 32'hA5,  0, 32'h0,   0, 32'h0);
    tbl[12] = mk(0, 0, 32'h0,   1, 0, 0,  1,  0, 0, 32'h0,   0, 32'h0,   0, 32'h0);
    tbl[13] = mk(1, 0, 32'hFF,  1, 0, 0,  1,  0, 0, 32'h0,   0, 32'h0,   0, 32'h0);
    tbl[14] = mk(0, 0, 32'h0,   1, 0, 0,  1,  0, 0, 32'h0,   0, 32'h0,   0, 32'h0);
    tbl[15] = mk(1, 7, 32'hA,   0, 0, 0,  1,  0, 0, 32'h0,   0, 32'h0,   0, 32'h0);
    tbl[16] = mk(1, 7, 32'hB,   0, 7, 8,  1,  0, 7, 32'hA,   1, 32'hA,   0, 32'h0);
    tbl[17] = mk(0, 0, 32'h0,   0, 7, 8,  1,  0, 7, 32'hA,   1, 32'hB,   0, 32'h0);
    tbl[18] = mk(0, 0, 32'h0,   1, 7, 7,  1,  1, 7, 32'hA,   1, 32'hB,   1, 32'hB);
    tbl[19] = mk(0, 0, 32'h0,   1, 7, 0,  1,  1, 7, 32'hB,   1, 32'hB,   0, 32'h0);
    tbl[20] = mk(0, 0, 32'h0,   1, 7, 0,  1,  0, 0, 32'h0,   0, 32'h0,   0, 32'h0);

    do_reset();
    @(negedge clk);
    chk_all("reset", 1'b1, 1'b0, '0, '0, 1'b0, '0, 1'b0, '0);
    @(posedge clk); #1;

    // Directed table
    foreach (tbl[i]) begin
      drive(tbl[i].v, tbl[i].a, tbl[i].d, tbl[i].dr, tbl[i].ra, tbl[i].rb);
      @(negedge clk);
      chk_all($sformatf("tbl%0d", i), tbl[i].e_rdy, tbl[i].e_wr, tbl[i].e_wa, tbl[i].e_wd,
              tbl[i].e_ha, tbl[i].e_da, tbl[i].e_hb, tbl[i].e_db);
      @(posedge clk);
      model_edge();
      #1;
    end

    // Steady occupancy of 2 with push+pop every cycle, across pointer wrap
    do_reset();
    cyc("fill0", 1'b1, 5'd9,  32'h900, 1'b0, 5'd9, 5'd0);
    cyc("fill1", 1'b1, 5'd10, 32'hA00, 1'b0, 5'd9, 5'd10);
    for (int i = 0; i < 10; i++)
      cyc($sformatf("pp%0d", i), 1'b1, ADDR_W'(11 + i), 32'h1000 + 32'(i), 1'b1,
          ADDR_W'(10 + i), ADDR_W'(11 + i));
    for (int i = 0; i < 3; i++)
      cyc($sformatf("tail%0d", i), 1'b0, '0, '0, 1'b1, 5'd20, 5'd19);

    // Async reset between clock edges with 3 entries queued
    cyc("pre0", 1'b1, 5'd1, 32'h31, 1'b0, 5'd0, 5'd0);
    cyc("pre1", 1'b1, 5'd2, 32'h32, 1'b0, 5'd0, 5'd0);
    cyc("pre2", 1'b1, 5'd3, 32'h33, 1'b0, 5'd1, 5'd3);
    drive(1'b0, '0, '0, 1'b1, 5'd1, 5'd3);
    #2;
    chk("pre_rst.Write_Reg", 32'(Write_Reg), 32'd1);
    #1 Reset = 1'b1;
    #1;
    mq.delete();
    chk_all("async_rst", 1'b1, 1'b0, '0, '0, 1'b0, '0, 1'b0, '0);
    @(posedge clk);
    #3 Reset = 1'b0;
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++)
      cyc($sformatf("post_rst%0d", i), 1'b0, '0, '0, 1'b1, 5'd1, 5'd2);

    // Random traffic against the reference model
    do_reset();
    for (int i = 0; i < 400; i++)
      cyc($sformatf("rnd%0d", i), logic'($urandom_range(0, 1)), ADDR_W'($urandom_range(0, 7)),
          32'($urandom), logic'($urandom_range(0, 9) < 6),
          ADDR_W'($urandom_range(0, 8)), ADDR_W'($urandom_range(0, 8)));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
